mux_pipe_stage: RTL
===================

// Module: mux_pipe_stage
// PURPOSE
//   Parametrised N:1 data select with a registered output and a valid/ready handshake.
//   Generalises the 2:1 datapath select to NUM_IN inputs of WIDTH bits.
//   A 2-entry skid buffer lets the MIPS32 pipeline stall downstream without losing a captured selection.
//   Used for operand/forwarding select between pipeline stages; flush supports branch squash.
// PARAMETERS
//   WIDTH     32   data width of each input and of the output
//   NUM_IN    4    number of data inputs, 2..16
//   SEL_W     2    select width; must satisfy 2**SEL_W >= NUM_IN
//   ERR_VAL   0    WIDTH-bit value output when sel >= NUM_IN
// PORTS
//   clk        in   1             rising-edge clock
//   reset      in   1             synchronous, active-high reset
//   flush      in   1             synchronous squash of all buffered entries
//   in_valid   in   1             upstream offers sel/data_in this cycle
//   in_ready   out  1             stage can accept this cycle
//   sel        in   SEL_W         input index, sampled with data on accept
//   data_in    in   NUM_IN*WIDTH  flattened inputs; input i = data_in[i*WIDTH +: WIDTH]
//   out_valid  out  1             out_data/out_sel hold a valid entry
//   out_ready  in   1             downstream consumes entry when out_valid&&out_ready
//   out_data   out  WIDTH         selected data of head entry
//   out_sel    out  SEL_W         sel value captured with head entry
//   out_err    out  1             head entry had sel >= NUM_IN
// BEHAVIOUR
//   One clock; reset is synchronous and active-high.
//   Reset: state=EMPTY; out_valid=0, out_data=0, out_sel=0, out_err=0; in_ready=1 next cycle; skid reg=0.
//   accept = in_valid && in_ready; pop = out_valid && out_ready.
//   Select evaluated at accept time only; later changes on sel/data_in do not affect captured entries.
//   sel >= NUM_IN: entry data = ERR_VAL, err bit = 1; entry still accepted and delivered.
//   Latency: accepted entry appears on out_data the next cycle when the stage was EMPTY or popping.
//   States (2-bit): EMPTY (no entries), ONE (head reg full), FULL (head + skid full).
//   in_ready = (state != FULL); function of state only, no combinational path from out_ready.
//   out_valid = (state != EMPTY).
//   EMPTY: accept -> ONE, head <= new entry; else stay.
//   ONE: accept&&pop -> ONE, head <= new. accept&&!pop -> FULL, skid <= new.
//        !accept&&pop -> EMPTY. Neither -> hold.
//   FULL: pop -> ONE, head <= skid. !pop -> hold. No accept possible.
//   Ordering strictly FIFO: head always older than skid.
//   Outputs stable while out_valid && !out_ready (no change to out_data/out_sel/out_err).
//   flush: next state EMPTY, out_valid=0. Any accept in the same cycle is discarded.
//          Any pop in the same cycle still counts downstream. Data regs may keep stale values.
//   reset has priority over flush; flush has priority over accept/pop updates.
//   reset or flush mid-stall (FULL) drops both entries; in_ready=1 the following cycle.
//   Widths: no arithmetic; out_sel is sel as captured (not truncated or clamped).
// TESTING
//   T1 reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1 after release.
//   T2 streaming: NUM_IN=4; data_in = {D3..D0} = {44,33,22,11}; sel 0,1,2,3 on consecutive cycles; out_ready=1
//      -> out_data 11,22,33,44 one cycle after each accept; in_ready stays 1.
//   T3 stall: out_ready=0, accept sel=1 then sel=2 -> state FULL, in_ready=0, out_data=22 held.
//      Raise out_ready -> 22 then 33 delivered in order, no loss or duplicate.
//   T4 bad select: NUM_IN=3, SEL_W=2, sel=3, ERR_VAL=32'hDEAD_BEEF -> out_data=DEADBEEF, out_err=1, out_sel=3.
//   T5 flush: in FULL with in_valid=1, pulse flush -> next cycle out_valid=0, in_ready=1.
//      Offered entry absent from output.
//   T6 random: random in_valid/out_ready/sel for 10k cycles vs. reference queue model
//      -> exact in-order data match; in_ready never depends on same-cycle out_ready.

Source files
------------

// File: rtl/mux_pipe_stage.sv
// rtl/mux_pipe_stage.sv - N:1 registered select stage with valid/ready handshake and 2-entry skid buffer
module mux_pipe_stage #(
  parameter int               WIDTH   = 32,
  parameter int               NUM_IN  = 4,
  parameter int               SEL_W   = 2,
  parameter logic [WIDTH-1:0] ERR_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [SEL_W-1:0] head_sel_q, head_sel_d;
  logic             head_err_q, head_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             skid_err_q, skid_err_d;

  logic [WIDTH-1:0] new_data;
  logic             new_err;
  logic             accept;
  logic             pop;

  // Out-of-range selects fall through the loop and keep ERR_VAL with the error flag set.
  always_comb begin
    new_data = ERR_VAL;
    new_err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        new_data = data_in[i*WIDTH +: WIDTH];
        new_err  = 1'b0;
      end
    end
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    head_err_d  = head_err_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          head_data_d = new_data;
          head_sel_d  = sel;
          head_err_d  = new_err;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_data_d = new_data;
          head_sel_d  = sel;
          head_err_d  = new_err;
        end else if (accept) begin
          state_d     = FULL;
          skid_data_d = new_data;
          skid_sel_d  = sel;
          skid_err_d  = new_err;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = ONE;
          head_data_d = skid_data_q;
          head_sel_d  = skid_sel_q;
          head_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash only clears occupancy; data registers are allowed to go stale.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_sel_q  <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      head_err_q  <= head_err_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign out_data = head_data_q;
  assign out_sel  = head_sel_q;
  assign out_err  = head_err_q;

endmodule
